// File: rtl/press_counter_to_digits_pkg.sv
// Shared constants and the count step function for the press counter.
// A step is one increment or decrement in either BCD or plain hex.
package press_counter_to_digits_pkg;

  localparam int         DEFAULT_DEBOUNCE_LIMIT = 250000;
  localparam logic [3:0] BCD_DIGIT_MAX          = 4'd9;
  localparam int         COUNT_WIDTH            = 8;

  // BCD steps carry or borrow per digit so that a nibble never leaves 0..9.
  function automatic logic [COUNT_WIDTH-1:0] step_count(
    input logic [COUNT_WIDTH-1:0] cur,
    input logic                   up,
    input logic                   bcd
  );
    logic [3:0] hi;
    logic [3:0] lo;
    hi = cur[7:4];
    lo = cur[3:0];
    if (!bcd) begin
      step_count = up ? cur + COUNT_WIDTH'(1) : cur - COUNT_WIDTH'(1);
    end else if (up) begin
      if (lo == BCD_DIGIT_MAX) begin
        lo = 4'd0;
        hi = (hi == BCD_DIGIT_MAX) ? 4'd0 : hi + 4'd1;
      end else begin
        lo = lo + 4'd1;
      end
      step_count = {hi, lo};
    end else begin
      if (lo == 4'd0) begin
        lo = BCD_DIGIT_MAX;
        hi = (hi == 4'd0) ? BCD_DIGIT_MAX : hi - 4'd1;
      end else begin
        lo = lo - 4'd1;
      end
      step_count = {hi, lo};
    end
  endfunction

endpackage

// File: rtl/press_counter_to_digits_debounce_filter.sv
// Switch debounce: the stable level flips only after the raw input has
// disagreed with it for DEBOUNCE_LIMIT consecutive clocks.
module debounce_filter
  import press_counter_to_digits_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Raw,
  output logic o_Stable
);

  localparam int CNT_W = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;

  logic [CNT_W-1:0] r_count;
  logic             r_stable;

  // Any edge where raw agrees with stable restarts the count, so glitches are lost.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_count  <= '0;
      r_stable <= 1'b0;
    end else if (i_Raw == r_stable) begin
      r_count <= '0;
    end else if (r_count == CNT_W'(DEBOUNCE_LIMIT - 1)) begin
      r_stable <= i_Raw;
      r_count  <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_Stable = r_stable;

endmodule

// File: rtl/press_counter_to_digits.sv
// Debounced up/down press counter presenting its count as two nibbles
// for the downstream per-digit 7-segment decoders.
module press_counter_to_digits
  import press_counter_to_digits_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
  parameter bit BCD_MODE       = 1'b1
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Switch_Inc,
  input  logic       i_Switch_Dec,
  output logic [3:0] o_Upper_Num,
  output logic [3:0] o_Lower_Num,
  output logic       o_Update
);

  logic                   w_inc_stable;
  logic                   w_dec_stable;
  logic                   w_inc_press;
  logic                   w_dec_press;
  logic                   w_change;
  logic [COUNT_WIDTH-1:0] w_next;
  logic                   r_inc_q;
  logic                   r_dec_q;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_update;

  debounce_filter #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_inc_filter (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Raw   (i_Switch_Inc),
    .o_Stable(w_inc_stable)
  );

  debounce_filter #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_dec_filter (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Raw   (i_Switch_Dec),
    .o_Stable(w_dec_stable)
  );

  assign w_inc_press = w_inc_stable & ~r_inc_q;
  assign w_dec_press = w_dec_stable & ~r_dec_q;

  // Simultaneous presses cancel: no count change and no update pulse.
  always_comb begin
    w_next   = r_count;
    w_change = 1'b0;
    if (w_inc_press ^ w_dec_press) begin
      w_change = 1'b1;
      w_next   = step_count(r_count, w_inc_press, BCD_MODE);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_inc_q  <= 1'b0;
      r_dec_q  <= 1'b0;
      r_count  <= '0;
      r_update <= 1'b0;
    end else begin
      r_inc_q  <= w_inc_stable;
      r_dec_q  <= w_dec_stable;
      r_count  <= w_next;
      r_update <= w_change;
    end
  end

  assign o_Upper_Num = r_count[7:4];
  assign o_Lower_Num = r_count[3:0];
  assign o_Update    = r_update;

endmodule

// File: tb/tb_press_counter_to_digits.sv
// Directed bench for press_counter_to_digits: one BCD and one hex instance
// share the same switches, with DEBOUNCE_LIMIT = 4.
module tb_press_counter_to_digits;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       sw_inc = 1'b0;
  logic       sw_dec = 1'b0;
  logic [3:0] bcd_upper, bcd_lower, hex_upper, hex_lower;
  logic       bcd_update, hex_update;

  int errors = 0;
  int checks = 0;
  int bcd_upd_cnt = 0;
  int hex_upd_cnt = 0;

  always #5 clk = ~clk;

  press_counter_to_digits #(.DEBOUNCE_LIMIT(4), .BCD_MODE(1'b1)) dut_bcd (
    .i_Clk       (clk),
    .i_Rst_L     (rst_l),
    .i_Switch_Inc(sw_inc),
    .i_Switch_Dec(sw_dec),
    .o_Upper_Num (bcd_upper),
    .o_Lower_Num (bcd_lower),
    .o_Update    (bcd_update)
  );

  press_counter_to_digits #(.DEBOUNCE_LIMIT(4), .BCD_MODE(1'b0)) dut_hex (
    .i_Clk       (clk),
    .i_Rst_L     (rst_l),
    .i_Switch_Inc(sw_inc),
    .i_Switch_Dec(sw_dec),
    .o_Upper_Num (hex_upper),
    .o_Lower_Num (hex_lower),
    .o_Update    (hex_update)
  );

  always @(negedge clk) begin
    if (bcd_update === 1'b1) bcd_upd_cnt++;
    if (hex_update === 1'b1) hex_upd_cnt++;
  end

  task automatic do_reset();
    @(negedge clk);
    rst_l  = 1'b0;
    sw_inc = 1'b0;
    sw_dec = 1'b0;
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
  endtask

  task automatic press(input logic inc, input logic dec);
    @(negedge clk);
    sw_inc = inc;
    sw_dec = dec;
    repeat (6) @(negedge clk);
    sw_inc = 1'b0;
    sw_dec = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_l  = 1'b0;
    sw_inc = 1'b0;
    sw_dec = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bcd_upper, bcd_lower, bcd_update} !== 9'd0) begin
      errors++;
      $display("FAIL reset_bcd: got %h%h upd=%b, want 00 upd=0", bcd_upper, bcd_lower, bcd_update);
    end
    checks++;
    if ({hex_upper, hex_lower, hex_update} !== 9'd0) begin
      errors++;
      $display("FAIL reset_hex: got %h%h upd=%b, want 00 upd=0", hex_upper, hex_lower, hex_update);
    end
    rst_l = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({bcd_upper, bcd_lower, bcd_update, hex_upper, hex_lower, hex_update} !== 18'd0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: bcd %h%h/%b hex %h%h/%b, want all 0",
                 i, bcd_upper, bcd_lower, bcd_update, hex_upper, hex_lower, hex_update);
      end
    end
  endtask

  task automatic test_glitch();
    int u0;
    do_reset();
    u0 = bcd_upd_cnt + hex_upd_cnt;
    @(negedge clk);
    sw_inc = 1'b1;
    repeat (3) @(negedge clk);
    sw_inc = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if ({bcd_upper, bcd_lower, hex_upper, hex_lower} !== 16'h0000) begin
      errors++;
      $display("FAIL glitch_count: bcd %h%h hex %h%h, want 00/00", bcd_upper, bcd_lower, hex_upper, hex_lower);
    end
    checks++;
    if (bcd_upd_cnt + hex_upd_cnt != u0) begin
      errors++;
      $display("FAIL glitch_update: %0d update pulses, want 0", bcd_upd_cnt + hex_upd_cnt - u0);
    end
  endtask

  task automatic test_clean_press();
    int u0;
    do_reset();
    u0 = bcd_upd_cnt;
    @(negedge clk);
    sw_inc = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({bcd_upper, bcd_lower, bcd_update} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL press_edge4: got %h%h upd=%b, want 00 upd=0", bcd_upper, bcd_lower, bcd_update);
    end
    @(negedge clk);
    checks++;
    if ({bcd_upper, bcd_lower, bcd_update} !== {8'h01, 1'b1}) begin
      errors++;
      $display("FAIL press_edge5: got %h%h upd=%b, want 01 upd=1", bcd_upper, bcd_lower, bcd_update);
    end
    checks++;
    if ({hex_upper, hex_lower, hex_update} !== {8'h01, 1'b1}) begin
      errors++;
      $display("FAIL press_edge5_hex: got %h%h upd=%b, want 01 upd=1", hex_upper, hex_lower, hex_update);
    end
    @(negedge clk);
    checks++;
    if (bcd_update !== 1'b0) begin
      errors++;
      $display("FAIL press_pulse_width: upd=%b one cycle later, want 0", bcd_update);
    end
    repeat (5) @(negedge clk);
    sw_inc = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if ({bcd_upper, bcd_lower} !== 8'h01 || bcd_upd_cnt - u0 != 1) begin
      errors++;
      $display("FAIL press_release: got %h%h pulses=%0d, want 01 pulses=1",
               bcd_upper, bcd_lower, bcd_upd_cnt - u0);
    end
  endtask

  task automatic test_bcd_wrap();
    logic [7:0] exp_b;
    logic [7:0] exp_h;
    do_reset();
    for (int i = 1; i <= 99; i++) begin
      press(1'b1, 1'b0);
      exp_b = {4'(i / 10), 4'(i % 10)};
      exp_h = 8'(i);
      checks++;
      if ({bcd_upper, bcd_lower} !== exp_b || bcd_upper > 4'd9 || bcd_lower > 4'd9) begin
        errors++;
        $display("FAIL bcd_inc step %0d: got %h%h, want %h", i, bcd_upper, bcd_lower, exp_b);
      end
      checks++;
      if ({hex_upper, hex_lower} !== exp_h) begin
        errors++;
        $display("FAIL hex_inc step %0d: got %h%h, want %h", i, hex_upper, hex_lower, exp_h);
      end
    end
    press(1'b1, 1'b0);
    checks++;
    if ({bcd_upper, bcd_lower, hex_upper, hex_lower} !== 16'h0064) begin
      errors++;
      $display("FAIL bcd_wrap_99: bcd %h%h hex %h%h, want 00/64", bcd_upper, bcd_lower, hex_upper, hex_lower);
    end
    press(1'b0, 1'b1);
    checks++;
    if ({bcd_upper, bcd_lower, hex_upper, hex_lower} !== 16'h9963) begin
      errors++;
      $display("FAIL bcd_borrow_00: bcd %h%h hex %h%h, want 99/63", bcd_upper, bcd_lower, hex_upper, hex_lower);
    end
  endtask

  task automatic test_hex_wrap();
    logic [7:0] exp_b;
    do_reset();
    press(1'b0, 1'b1);
    checks++;
    if ({hex_upper, hex_lower} !== 8'hFF) begin
      errors++;
      $display("FAIL hex_dec_00: got %h%h, want ff", hex_upper, hex_lower);
    end
    checks++;
    if ({bcd_upper, bcd_lower} !== 8'h99) begin
      errors++;
      $display("FAIL bcd_dec_00: got %h%h, want 99", bcd_upper, bcd_lower);
    end
    press(1'b1, 1'b0);
    checks++;
    if ({hex_upper, hex_lower, bcd_upper, bcd_lower} !== 16'h0000) begin
      errors++;
      $display("FAIL hex_inc_ff: hex %h%h bcd %h%h, want 00/00", hex_upper, hex_lower, bcd_upper, bcd_lower);
    end
    for (int i = 1; i <= 16; i++) begin
      press(1'b1, 1'b0);
      exp_b = {4'(i / 10), 4'(i % 10)};
      checks++;
      if ({hex_upper, hex_lower} !== 8'(i) || {bcd_upper, bcd_lower} !== exp_b) begin
        errors++;
        $display("FAIL hex_count step %0d: hex %h%h want %h, bcd %h%h want %h",
                 i, hex_upper, hex_lower, 8'(i), bcd_upper, bcd_lower, exp_b);
      end
    end
  endtask

  task automatic test_simultaneous();
    int u0;
    do_reset();
    u0 = bcd_upd_cnt + hex_upd_cnt;
    press(1'b1, 1'b1);
    checks++;
    if ({bcd_upper, bcd_lower, hex_upper, hex_lower} !== 16'h0000 || bcd_upd_cnt + hex_upd_cnt != u0) begin
      errors++;
      $display("FAIL simul_zero: bcd %h%h hex %h%h pulses=%0d, want 00/00 pulses=0",
               bcd_upper, bcd_lower, hex_upper, hex_lower, bcd_upd_cnt + hex_upd_cnt - u0);
    end
    press(1'b1, 1'b0);
    u0 = bcd_upd_cnt;
    press(1'b1, 1'b1);
    checks++;
    if ({bcd_upper, bcd_lower} !== 8'h01 || bcd_upd_cnt != u0) begin
      errors++;
      $display("FAIL simul_one: got %h%h pulses=%0d, want 01 pulses=0", bcd_upper, bcd_lower, bcd_upd_cnt - u0);
    end
  endtask

  task automatic test_held_through_reset();
    int u0;
    @(negedge clk);
    rst_l  = 1'b0;
    sw_inc = 1'b1;
    sw_dec = 1'b0;
    repeat (3) @(negedge clk);
    u0 = bcd_upd_cnt;
    rst_l = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({bcd_upper, bcd_lower, bcd_update} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL held_edge4: got %h%h upd=%b, want 00 upd=0", bcd_upper, bcd_lower, bcd_update);
    end
    @(negedge clk);
    checks++;
    if ({bcd_upper, bcd_lower, bcd_update} !== {8'h01, 1'b1}) begin
      errors++;
      $display("FAIL held_edge5: got %h%h upd=%b, want 01 upd=1", bcd_upper, bcd_lower, bcd_update);
    end
    repeat (10) @(negedge clk);
    checks++;
    if ({bcd_upper, bcd_lower} !== 8'h01 || bcd_upd_cnt - u0 != 1) begin
      errors++;
      $display("FAIL held_once: got %h%h pulses=%0d, want 01 pulses=1", bcd_upper, bcd_lower, bcd_upd_cnt - u0);
    end
    sw_inc = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_clean_press();
    test_bcd_wrap();
    test_hex_wrap();
    test_simultaneous();
    test_held_through_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
